// File: rtl/pipe_ctrl_stall.sv
// ----------------------------------------------------------------------------
// pipe_ctrl_stall
//   ID-stage control for the 5-stage MIPS pipeline. Decodes the ID opcode into
//   the EX/MEM/WB control bits and sequences a multi-cycle DIV. The DIV stalls
//   PC/IF/ID and bubbles ID/EX for DIV_CYCLES cycles, then issues one HI/LO
//   writeback strobe.
//
//   Optional feature macro: CTRL_DIV_EARLY_DONE_EN
//     defined   : div_done ends the BUSY phase early (the counter still acts
//                 as a timeout)
//     undefined : div_done is ignored and the DIV latency is fixed
//
//   Parameters
//     OPW         opcode width
//     DIV_CYCLES  divider latency in cycles (>= 2)
//     CW          busy-counter width, derived, not overridable
//
//   Ports
//     clk, rst            clock (rising edge), synchronous active-high reset
//     valid_id            ID holds a real instruction
//     opcode              ID-stage opcode
//     cmp_eq              ID register comparator result (rs == rt)
//     div_done            divider finished (early-done builds only)
//     PCsrc               00 PC+4, 01 jump target, 10 branch target
//     IFflush             squash IF/ID
//     signExt .. noDest   decode controls to the ID/EX register
//     opcodeOut           opcode to EX, 0 while bubbling
//     stall               hold PC and IF/ID, bubble ID/EX
//     div_start           one-cycle divider start pulse
//     div_wb              DIV result (HI/LO) writeback strobe
//     busy_cnt            cycles remaining in the DIV
//
//   Opcode map: RTYPE 00, J 02, JAL 03, BEQ 04, BNE 05, ADDI 08, ORI 0D,
//   LUI 0F, DIV 1A, MULTYPE 1C, LW 23, SW 2B.
// ----------------------------------------------------------------------------
module pipe_ctrl_stall #(
    parameter  int OPW        = 6,
    parameter  int DIV_CYCLES = 32,
    localparam int CW         = $clog2(DIV_CYCLES + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           valid_id,
    input  logic [OPW-1:0] opcode,
    input  logic           cmp_eq,
    input  logic           div_done,
    output logic [1:0]     PCsrc,
    output logic           IFflush,
    output logic           signExt,
    output logic           IorD,
    output logic           regWrite,
    output logic           memToReg,
    output logic           memRead,
    output logic           memWrite,
    output logic           ALUsrc,
    output logic           regDst,
    output logic           noDest,
    output logic [OPW-1:0] opcodeOut,
    output logic           stall,
    output logic           div_start,
    output logic           div_wb,
    output logic [CW-1:0]  busy_cnt
);

    localparam logic [OPW-1:0] OP_RTYPE   = OPW'(6'h00);
    localparam logic [OPW-1:0] OP_J       = OPW'(6'h02);
    localparam logic [OPW-1:0] OP_JAL     = OPW'(6'h03);
    localparam logic [OPW-1:0] OP_BEQ     = OPW'(6'h04);
    localparam logic [OPW-1:0] OP_BNE     = OPW'(6'h05);
    localparam logic [OPW-1:0] OP_ADDI    = OPW'(6'h08);
    localparam logic [OPW-1:0] OP_ORI     = OPW'(6'h0D);
    localparam logic [OPW-1:0] OP_LUI     = OPW'(6'h0F);
    localparam logic [OPW-1:0] OP_DIV     = OPW'(6'h1A);
    localparam logic [OPW-1:0] OP_MULTYPE = OPW'(6'h1C);
    localparam logic [OPW-1:0] OP_LW      = OPW'(6'h23);
    localparam logic [OPW-1:0] OP_SW      = OPW'(6'h2B);

    localparam logic [CW-1:0] CNT_LOAD = CW'(DIV_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          early_done;
    logic          div_req;
    logic          bubble;

`ifdef CTRL_DIV_EARLY_DONE_EN
    assign early_done = div_done;
`else
    // The divider's done flag has no effect in the fixed-latency build.
    logic unused_div_done;
    assign unused_div_done = div_done;
    assign early_done      = 1'b0;
`endif

    // A real DIV in ID; rst gates it so nothing starts during reset.
    assign div_req = valid_id && (opcode == OP_DIV) && !rst;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            S_IDLE: begin
                if (div_req) begin
                    state_nx = S_BUSY;
                    cnt_nx   = CNT_LOAD;
                end
            end
            S_BUSY: begin
                // Saturating decrement; cnt <= 1 also covers a stray zero.
                cnt_nx = (cnt != '0) ? cnt - CW'(1) : '0;
                if (cnt <= CW'(1) || early_done) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                // The DIV leaves ID this cycle as a bubble; never restart it.
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // Output logic
    always_comb begin
        div_start = (state == S_IDLE) && div_req;
        stall     = ((state == S_IDLE) && div_req) || (state == S_BUSY);
        div_wb    = (state == S_DONE);
        busy_cnt  = cnt;

        // DONE also bubbles: the instruction leaving ID is the finished DIV.
        bubble    = !valid_id || stall || (state == S_DONE);

        PCsrc     = 2'b00;
        IFflush   = 1'b0;
        signExt   = 1'b0;
        IorD      = 1'b0;
        regWrite  = 1'b0;
        memToReg  = 1'b0;
        memRead   = 1'b0;
        memWrite  = 1'b0;
        ALUsrc    = 1'b0;
        regDst    = 1'b0;
        noDest    = 1'b0;
        opcodeOut = '0;

        if (!bubble) begin
            opcodeOut = opcode;
            case (opcode)
                OP_RTYPE, OP_MULTYPE: begin
                    regWrite = 1'b1;
                    regDst   = 1'b1;
                end
                OP_ADDI, OP_ORI: begin
                    regWrite = 1'b1;
                    ALUsrc   = 1'b1;
                end
                OP_LUI: begin
                    regWrite = 1'b1;
                    ALUsrc   = 1'b1;
                    signExt  = 1'b1;
                end
                OP_BEQ: begin
                    if (cmp_eq) begin
                        PCsrc   = 2'b10;
                        IFflush = 1'b1;
                    end
                end
                OP_BNE: begin
                    if (!cmp_eq) begin
                        PCsrc   = 2'b10;
                        IFflush = 1'b1;
                    end
                end
                OP_J: begin
                    PCsrc = 2'b01;
                end
                OP_JAL: begin
                    PCsrc  = 2'b01;
                    noDest = 1'b1;
                end
                OP_LW: begin
                    regWrite = 1'b1;
                    IorD     = 1'b1;
                    memToReg = 1'b1;
                    memRead  = 1'b1;
                    ALUsrc   = 1'b1;
                end
                OP_SW: begin
                    IorD     = 1'b1;
                    memWrite = 1'b1;
                    ALUsrc   = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
